// File: rtl/final_adder_pkg.sv
// Shared constants for the registered ripple-carry adder/subtractor.
package final_adder_pkg;

  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam int   ADDER_W = 4;

endpackage : final_adder_pkg

// File: rtl/final_full_adder_if.sv
// Operand/result bundle for final_full_adder. The ovf wire exists only
// when FINAL_FULL_ADDER_OVF_EN is defined.
interface final_full_adder_if
  import final_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_W
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sel;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef FINAL_FULL_ADDER_OVF_EN
  logic             ovf;

  modport master (output a, b, cin, sel, input  s, cout, ovf);
  modport slave  (input  a, b, cin, sel, output s, cout, ovf);
`else
  modport master (output a, b, cin, sel, input  s, cout);
  modport slave  (input  a, b, cin, sel, output s, cout);
`endif
endinterface : final_full_adder_if

// File: rtl/fa_cell.sv
// One-bit full adder; the ripple-chain building block.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic p;

  assign p    = a_i ^ b_i;
  assign s_o  = p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & p);

endmodule : fa_cell

// File: rtl/final_full_adder.sv
// Registered WIDTH-bit ripple add/sub with one cycle of latency.
// Optional signed-overflow output enabled by FINAL_FULL_ADDER_OVF_EN.
module final_full_adder
  import final_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_W
) (
  input  logic               clk,
  input  logic               rst,
  final_full_adder_if.slave  bus
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  // Subtract is a + ~b + ~cin, so both b and the carry-in flip on sel.
  assign sub  = (bus.sel == OP_SUB);
  assign bx   = bus.b ^ {WIDTH{sub}};
  assign c[0] = bus.cin ^ sub;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      fa_cell u_cell (
        .a_i  (bus.a[gi]),
        .b_i  (bx[gi]),
        .ci_i (c[gi]),
        .s_o  (s_d[gi]),
        .co_o (c[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= c[WIDTH];
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;

`ifdef FINAL_FULL_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= c[WIDTH] ^ c[WIDTH-1];
  end

  assign bus.ovf = ovf_q;
`endif

endmodule : final_full_adder

// File: tb/tb_final_full_adder.sv
// Directed and exhaustive self-checking bench for final_full_adder (WIDTH=4).
module tb_final_full_adder;
  import final_adder_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  final_full_adder_if #(.WIDTH(W)) bus ();

  final_full_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Reference: {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic sel);
    int ua, ub, sa, sb, r, sr;
    logic cout_m, ovf_m;
    logic [3:0] s_m;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (sel == OP_ADD) begin
      r  = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      cout_m = (r >= 16);
    end else begin
      r  = ua - ub - int'(cin);
      sr = sa - sb - int'(cin);
      cout_m = (r >= 0);
    end
    s_m   = 4'(r);
    ovf_m = (sr > 7) || (sr < -8);
    return {ovf_m, cout_m, s_m};
  endfunction

  // Drive one op, clock it, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic sel, input logic r);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sel = sel; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] s_e, input logic cout_e);
    check({tag, ".s"}, 8'(bus.s), 8'(s_e));
    check({tag, ".cout"}, 8'(bus.cout), 8'(cout_e));
  endtask

  task automatic check_ovf(input string tag, input logic ovf_e);
`ifdef FINAL_FULL_ADDER_OVF_EN
    check({tag, ".ovf"}, 8'(bus.ovf), 8'(ovf_e));
`else
    if (ovf_e === 1'bx) $display("note: %s", tag);
`endif
  endtask

  initial begin
    logic [5:0] e;

    // Reset with hostile inputs
    for (int i = 0; i < 2; i++) begin
      step(4'hF, 4'hF, 1'b1, OP_ADD, 1'b1);
      check_out($sformatf("reset%0d", i), 4'h0, 1'b0);
      check_ovf($sformatf("reset%0d", i), 1'b0);
    end

    step(4'b0010, 4'b0001, 1'b0, OP_ADD, 1'b0); check_out("add", 4'b0011, 1'b0);
    step(4'b0010, 4'b0001, 1'b1, OP_ADD, 1'b0); check_out("add_cin", 4'b0100, 1'b0);
    step(4'b1111, 4'b0001, 1'b0, OP_ADD, 1'b0); check_out("add_wrap", 4'b0000, 1'b1);
    check_ovf("add_wrap", 1'b0);
    step(4'b0111, 4'b0001, 1'b0, OP_ADD, 1'b0); check_out("add_ovf", 4'b1000, 1'b0);
    check_ovf("add_ovf", 1'b1);
    step(4'b0010, 4'b0001, 1'b0, OP_SUB, 1'b0); check_out("sub", 4'b0001, 1'b1);
    step(4'b0001, 4'b0010, 1'b0, OP_SUB, 1'b0); check_out("sub_borrow", 4'b1111, 1'b0);
    check_ovf("sub_borrow", 1'b0);
    step(4'b0101, 4'b0011, 1'b1, OP_SUB, 1'b0); check_out("sub_bin", 4'b0001, 1'b1);
    step(4'b0000, 4'b0001, 1'b0, OP_SUB, 1'b0); check_out("zero_minus_one", 4'b1111, 1'b0);
    step(4'b1000, 4'b0001, 1'b0, OP_SUB, 1'b0); check_out("sub_ovf", 4'b0111, 1'b1);
    check_ovf("sub_ovf", 1'b1);

    // Back-to-back add/sub/add, then a reset in the middle of the stream
    step(4'b0011, 4'b0100, 1'b0, OP_ADD, 1'b0); check_out("b2b_add0", 4'b0111, 1'b0);
    step(4'b0110, 4'b0010, 1'b1, OP_SUB, 1'b0); check_out("b2b_sub", 4'b0011, 1'b1);
    step(4'b1001, 4'b1000, 1'b1, OP_ADD, 1'b0); check_out("b2b_add1", 4'b0010, 1'b1);
    step(4'b1110, 4'b0001, 1'b0, OP_ADD, 1'b1); check_out("mid_reset", 4'b0000, 1'b0);
    check_ovf("mid_reset", 1'b0);
    step(4'b0100, 4'b0101, 1'b0, OP_SUB, 1'b0); check_out("after_reset", 4'b1111, 1'b0);

    // Exhaustive sweep against the integer model
    for (int v = 0; v < 1024; v++) begin
      logic [9:0] vv;
      vv = 10'(v);
      step(vv[3:0], vv[7:4], vv[8], vv[9], 1'b0);
      e = model(vv[3:0], vv[7:4], vv[8], vv[9]);
      check_out($sformatf("exh%0d", v), e[3:0], e[4]);
      check_ovf($sformatf("exh%0d", v), e[5]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_final_full_adder

// File: doc/final_full_adder.md
Name: final_full_adder

Overview:
- Registered WIDTH-bit ripple-carry adder/subtractor with carry/borrow in and out.
- `sel` chooses between add (a+b+cin) and subtract (a−b−cin).
- Results are registered on the clock, giving one cycle of latency.
- Used as the arithmetic leaf of the datapath wherever a small synchronous add/sub is needed.

Parameters:
- WIDTH, 4, operand and sum width in bits (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A, unsigned / two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sel  input  1  operation select: 0 = add, 1 = subtract.
- s  output  WIDTH  registered result.
- cout  output  1  registered carry-out. For subtract this is NOT borrow.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - On a clk rising edge with rst=1, s and cout become 0.
  - rst has priority over any input in the same cycle.
  - Reset mid-operation discards the in-flight result.
- Combinational core:
  - Effective B = b XOR {WIDTH{sel}}.
  - Effective carry-in = cin XOR sel.
  - Ripple chain of WIDTH full-adder cells: bit i sum = a[i]^bx[i]^c[i]; c[i+1] = a[i]&bx[i] | c[i]&(a[i]^bx[i]).
  - c[0] = effective carry-in; cout = c[WIDTH].
- Add (sel=0): {cout,s} = a + b + cin, computed modulo 2^(WIDTH+1).
- Subtract (sel=1): {cout,s} = a + ~b + ~cin, i.e. a − b − cin.
  - cout=1 means no borrow (a ≥ b+cin, unsigned).
  - cout=0 means borrow; s then wraps in two's complement.
- Latency: inputs sampled at rising edge N appear on s/cout after edge N; outputs hold between edges.
- No handshake. A new operation is accepted every cycle and the result is valid every non-reset cycle.
- Wrap-around:
  - All-ones + 1 (add) yields s=0, cout=1.
  - 0 − 1 yields s=all-ones, cout=0.
- X on inputs is not masked. Inputs must be known at the sampling edge.

Optional Feature:
- Macro: FINAL_FULL_ADDER_OVF_EN.
- When defined:
  - Extra output port `ovf`, 1 bit, registered, reset to 0.
  - ovf = c[WIDTH] XOR c[WIDTH−1] (signed two's-complement overflow) for both add and subtract, same latency as s.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package final_adder_pkg holds:
  - localparam OP_ADD=1'b0 and OP_SUB=1'b1.
  - Default width constant ADDER_W=4.
- Sub-module fa_cell: 1-bit full adder (a, b, ci -> s, co).
  - Instantiated WIDTH times via generate to form the ripple chain.
  - Top level adds the sel inversion, output registers, reset and optional ovf.

Test Plan:
- Reset: assert rst for 2 cycles with a=F, b=F, cin=1 -> s=0, cout=0 (and ovf=0 when enabled) after each edge.
- Basic add: a=0010, b=0001, cin=0, sel=0 -> one cycle later s=0011, cout=0. Same operands with cin=1 -> s=0100.
- Add wrap: a=1111, b=0001, cin=0, sel=0 -> s=0000, cout=1. With OVF_EN, a=0111, b=0001 -> s=1000, ovf=1.
- Subtract:
  - a=0010, b=0001, sel=1, cin=0 -> s=0001, cout=1.
  - a=0001, b=0010 -> s=1111, cout=0.
  - a=0101, b=0011, cin=1 -> s=0001, cout=1.
- Back-to-back plus mid-stream reset:
  - Apply an add, then a subtract, then an add on consecutive cycles; each result appears exactly one cycle after its inputs.
  - Assert rst on cycle 2 -> that cycle's output is 0 and the following result is correct.
- Exhaustive: all 2^10 combinations of a, b, cin, sel, checked against the reference equations above with one-cycle delay.
